// File: rtl/nonmax_thresh_stream_if.sv
// Column stream into the NMS/threshold stage and the classified pixel stream out of it.
interface nonmax_thresh_stream_if #(
    parameter int unsigned BIT_LENGTH = 5,
    parameter int unsigned IMG_WIDTH  = 960
);
    localparam int unsigned COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            angle;
    logic [BIT_LENGTH-1:0] pixel_in0;
    logic [BIT_LENGTH-1:0] pixel_in1;
    logic [BIT_LENGTH-1:0] pixel_in2;
    logic                  out_valid;
    logic [BIT_LENGTH-1:0] pixel_out;
    logic [1:0]            edge_class;
    logic [COL_W-1:0]      out_col;

    modport master (
        output in_valid, angle, pixel_in0, pixel_in1, pixel_in2,
        input  in_ready, out_valid, pixel_out, edge_class, out_col
    );

    modport slave (
        input  in_valid, angle, pixel_in0, pixel_in1, pixel_in2,
        output in_ready, out_valid, pixel_out, edge_class, out_col
    );
endinterface

// File: rtl/nonmax_thresh_stream.sv
// Streaming non-maximum suppression with double-threshold edge classification.
// The 3x3 window is formed by two registered columns plus the beat being accepted,
// so column k-1 is resolved on the edge that accepts column k and is output next cycle.
module nonmax_thresh_stream #(
    parameter int unsigned BIT_LENGTH = 5,
    parameter int unsigned IMG_WIDTH  = 960,
    parameter int unsigned IMG_HEIGHT = 720
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  nms_en,
    input  logic [BIT_LENGTH-1:0] thr_low,
    input  logic [BIT_LENGTH-1:0] thr_high,
    output logic                  busy,
    output logic                  frame_done,
    nonmax_thresh_stream_if.slave bus
);
    localparam int unsigned BW    = BIT_LENGTH;
    localparam int unsigned COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // Latched frame configuration
    logic          cfg_nms;
    logic [BW-1:0] cfg_lo;
    logic [BW-1:0] cfg_hi;

    // Position of the next column to be accepted
    logic [COL_W-1:0] col_cnt;
    logic [ROW_W-1:0] row_cnt;
    logic             last_row;

    // Window: left column, centre column (with its angle), incoming beat on the right
    logic [2:0][BW-1:0] left_q;
    logic [2:0][BW-1:0] ctr_q;
    logic [1:0]         ctr_ang_q;
    logic [2:0][BW-1:0] in_col;

    // Registered stream outputs
    logic             in_ready_q;
    logic             out_valid_q;
    logic [BW-1:0]    pixel_out_q;
    logic [1:0]       edge_class_q;
    logic [COL_W-1:0] out_col_q;

    // Decoded control
    logic start_ok;
    logic accept;
    logic col_last;
    logic row_last;
    logic emit;
    logic in_ready_d;
    logic busy_d;
    logic done_d;

    // Suppression / classification datapath
    logic [BW-1:0] nb_a;
    logic [BW-1:0] nb_b;
    logic          suppress;
    logic          border;
    logic [BW-1:0] pix_v;
    logic [1:0]    cls_v;

    assign in_col   = {bus.pixel_in2, bus.pixel_in1, bus.pixel_in0};
    assign col_last = (col_cnt == COL_LAST);
    assign row_last = (row_cnt == ROW_LAST);
    assign start_ok = start && ((state == IDLE) || (state == DONE));
    assign accept   = (state == RUN) && bus.in_valid;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (accept && col_last) state_next = FLUSH;
            FLUSH:   state_next = last_row ? DONE : RUN;
            DONE:    if (start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    // Control decode feeding the registered outputs
    always_comb begin
        in_ready_d = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        emit       = 1'b0;
        in_ready_d = (state_next == RUN);
        busy_d     = (state_next == RUN) || (state_next == FLUSH);
        done_d     = (state == FLUSH) && (state_next == DONE);
        emit       = (accept && (col_cnt != '0)) || (state == FLUSH);
    end

    // Neighbour selection, suppression, border forcing and classification of the centre pixel
    always_comb begin
        nb_a = '0;
        nb_b = '0;
        case (ctr_ang_q)
            2'd0: begin
                nb_a = left_q[1];
                nb_b = in_col[1];
            end
            2'd1: begin
                nb_a = left_q[2];
                nb_b = in_col[0];
            end
            2'd2: begin
                nb_a = ctr_q[0];
                nb_b = ctr_q[2];
            end
            default: begin
                nb_a = left_q[0];
                nb_b = in_col[2];
            end
        endcase
        suppress = cfg_nms && ((nb_a > ctr_q[1]) || (nb_b > ctr_q[1]));
        // col_cnt==1 means the output is column 0; FLUSH always emits the last column
        border   = (state == FLUSH) || (col_cnt == COL_W'(1)) ||
                   (row_cnt == '0) || row_last;
        pix_v    = (border || suppress) ? '0 : ctr_q[1];
        if (border) begin
            cls_v = 2'b00;
        end else if (pix_v >= cfg_hi) begin
            cls_v = 2'b10;
        end else if ((pix_v >= cfg_lo) && (pix_v != '0)) begin
            cls_v = 2'b01;
        end else begin
            cls_v = 2'b00;
        end
    end

    // Configuration latch, position counters and window shift
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_nms   <= 1'b0;
            cfg_lo    <= '0;
            cfg_hi    <= '0;
            col_cnt   <= '0;
            row_cnt   <= '0;
            last_row  <= 1'b0;
            left_q    <= '0;
            ctr_q     <= '0;
            ctr_ang_q <= '0;
        end else begin
            if (start_ok) begin
                cfg_nms  <= nms_en;
                cfg_lo   <= thr_low;
                cfg_hi   <= thr_high;
                col_cnt  <= '0;
                row_cnt  <= '0;
                last_row <= 1'b0;
            end
            if (accept) begin
                left_q    <= ctr_q;
                ctr_q     <= in_col;
                ctr_ang_q <= bus.angle;
                col_cnt   <= col_last ? '0 : col_cnt + COL_W'(1);
                if (col_last) begin
                    row_cnt  <= row_last ? '0 : row_cnt + ROW_W'(1);
                    last_row <= row_last;
                end
            end
        end
    end

    // Output registers; pixel/class/column hold between beats
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_ready_q   <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            out_valid_q  <= 1'b0;
            pixel_out_q  <= '0;
            edge_class_q <= '0;
            out_col_q    <= '0;
        end else begin
            in_ready_q  <= in_ready_d;
            busy        <= busy_d;
            frame_done  <= done_d;
            out_valid_q <= emit;
            if (emit) begin
                pixel_out_q  <= pix_v;
                edge_class_q <= cls_v;
                out_col_q    <= (state == FLUSH) ? COL_LAST : col_cnt - COL_W'(1);
            end
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.pixel_out  = pixel_out_q;
    assign bus.edge_class = edge_class_q;
    assign bus.out_col    = out_col_q;

endmodule

// File: tb/tb_nonmax_thresh_stream.sv
// Randomised and directed bench for nonmax_thresh_stream against a per-pixel reference model.
module tb_nonmax_thresh_stream;
    localparam int unsigned BL = 5;
    localparam int unsigned W  = 4;
    localparam int unsigned H  = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          nms_en = 1'b0;
    logic [BL-1:0] thr_low = '0;
    logic [BL-1:0] thr_high = '0;
    logic          busy;
    logic          frame_done;

    nonmax_thresh_stream_if #(.BIT_LENGTH(BL), .IMG_WIDTH(W)) bus ();

    nonmax_thresh_stream #(.BIT_LENGTH(BL), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .nms_en     (nms_en),
        .thr_low    (thr_low),
        .thr_high   (thr_high),
        .busy       (busy),
        .frame_done (frame_done),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // Image under test: per (row, column) the three input rows and the centre angle
    int top [H][W];
    int mid [H][W];
    int bot [H][W];
    int ang [H][W];

    int q_pix[$];
    int q_cls[$];
    int q_col[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Collect every output beat
    always @(negedge clk) begin
        if (reset && bus.out_valid === 1'b1) begin
            q_pix.push_back(int'(bus.pixel_out));
            q_cls.push_back(int'(bus.edge_class));
            q_col.push_back(int'(bus.out_col));
        end
    end

    function automatic bit is_border(input int r, input int c);
        return (r == 0) || (r == H - 1) || (c == 0) || (c == W - 1);
    endfunction

    // Reference: compare centre against the neighbour pair chosen by the angle
    function automatic int exp_pix(input int r, input int c, input int nms);
        int ctr, a, b;
        if (is_border(r, c)) return 0;
        ctr = mid[r][c];
        case (ang[r][c])
            0:       begin a = mid[r][c-1]; b = mid[r][c+1]; end
            1:       begin a = bot[r][c-1]; b = top[r][c+1]; end
            2:       begin a = top[r][c];   b = bot[r][c];   end
            default: begin a = top[r][c-1]; b = bot[r][c+1]; end
        endcase
        if (nms != 0 && (a > ctr || b > ctr)) return 0;
        return ctr;
    endfunction

    function automatic int exp_cls(input int r, input int c, input int px, input int lo, input int hi);
        if (is_border(r, c)) return 0;
        if (px >= hi) return 2;
        if (px >= lo && px != 0) return 1;
        return 0;
    endfunction

    task automatic clear_img();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                top[r][c] = 0; mid[r][c] = 0; bot[r][c] = 0; ang[r][c] = 0;
            end
    endtask

    task automatic rand_img();
        int lim;
        lim = ($urandom_range(0, 1) != 0) ? 31 : 6;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                top[r][c] = $urandom_range(0, lim);
                mid[r][c] = $urandom_range(0, lim);
                bot[r][c] = $urandom_range(0, lim);
                ang[r][c] = $urandom_range(0, 3);
            end
    endtask

    // Place a value at one member of an angle's neighbour pair around (1,1)
    task automatic put_nb(input int a, input int sel, input int val);
        case (a)
            0:       if (sel != 0) mid[1][2] = val; else mid[1][0] = val;
            1:       if (sel != 0) top[1][2] = val; else bot[1][0] = val;
            2:       if (sel != 0) bot[1][1] = val; else top[1][1] = val;
            default: if (sel != 0) bot[1][2] = val; else top[1][0] = val;
        endcase
    endtask

    task automatic start_frame(input int nms, input int lo, input int hi);
        @(negedge clk);
        start = 1'b1; nms_en = nms[0]; thr_low = BL'(lo); thr_high = BL'(hi);
        @(negedge clk);
        // Scramble configuration inputs after start; the DUT must use the latched copy
        start = 1'b0; nms_en = 1'($urandom); thr_low = BL'($urandom); thr_high = BL'($urandom);
    endtask

    task automatic drive_frame(input int pct, input int max_beats, input bit inject);
        int idx, cyc, r, c;
        bit rdy, flush_chk;
        idx = 0; cyc = 0; flush_chk = 0;
        while (idx < max_beats && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            rdy = bus.in_ready;
            if (flush_chk) begin
                check("flush_in_ready", 32'(rdy), 0);
                flush_chk = 0;
            end
            start = inject && (cyc == 6);
            if ($urandom_range(0, 99) < pct) begin
                bus.in_valid = 1'b0;
            end else begin
                r = idx / W; c = idx % W;
                bus.pixel_in0 = BL'(top[r][c]);
                bus.pixel_in1 = BL'(mid[r][c]);
                bus.pixel_in2 = BL'(bot[r][c]);
                bus.angle     = 2'(ang[r][c]);
                bus.in_valid  = 1'b1;
                if (rdy) begin
                    if (c == W - 1) flush_chk = 1;
                    idx++;
                end
            end
        end
        if (idx < max_beats) check("drive_timeout", 32'(idx), 32'(max_beats));
        if (max_beats == W * H) begin
            @(negedge clk);
            start = 1'b0; bus.in_valid = 1'b0;
            check("end_flush_in_ready", 32'(bus.in_ready), 0);
            check("frame_done_early", 32'(frame_done), 0);
            @(negedge clk);
            check("frame_done_pulse", 32'(frame_done), 1);
            check("done_busy", 32'(busy), 0);
            check("done_in_ready", 32'(bus.in_ready), 0);
            @(negedge clk);
            check("frame_done_clear", 32'(frame_done), 0);
        end
    endtask

    task automatic check_frame(input int nms, input int lo, input int hi, input string tag);
        int n, r, c, px;
        check($sformatf("%s_beats", tag), 32'(q_pix.size()), 32'(W * H));
        n = (q_pix.size() < W * H) ? q_pix.size() : W * H;
        for (int i = 0; i < n; i++) begin
            r = i / W; c = i % W;
            px = exp_pix(r, c, nms);
            check($sformatf("%s_px_r%0dc%0d", tag, r, c), 32'(q_pix[i]), 32'(px));
            check($sformatf("%s_cls_r%0dc%0d", tag, r, c), 32'(q_cls[i]), 32'(exp_cls(r, c, px, lo, hi)));
            check($sformatf("%s_col_r%0dc%0d", tag, r, c), 32'(q_col[i]), 32'(c));
        end
    endtask

    task automatic run(input int nms, input int lo, input int hi, input int pct,
                       input bit inject, input string tag);
        q_pix.delete(); q_cls.delete(); q_col.delete();
        start_frame(nms, lo, hi);
        drive_frame(pct, W * H, inject);
        check_frame(nms, lo, hi, tag);
    endtask

    // Pixel/class of the beat at row 1, column c of the last frame
    task automatic check_r1(input string tag, input int c, input int px, input int cls);
        if (q_pix.size() > W + c) begin
            check({tag, "_px"}, 32'(q_pix[W + c]), 32'(px));
            check({tag, "_cls"}, 32'(q_cls[W + c]), 32'(cls));
        end else begin
            check({tag, "_missing"}, 32'(q_pix.size()), 32'(W * H));
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
        check({tag, "_pixel_out"}, 32'(bus.pixel_out), 0);
        check({tag, "_edge_class"}, 32'(bus.edge_class), 0);
        check({tag, "_out_col"}, 32'(bus.out_col), 0);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_frame_done"}, 32'(frame_done), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lo, hi, nms;
        bus.in_valid = 1'b0; bus.angle = '0;
        bus.pixel_in0 = '0; bus.pixel_in1 = '0; bus.pixel_in2 = '0;

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b1;

        // Worked example: centre row {3,12,9,20}, bright pixels on border rows
        clear_img();
        mid[1][0] = 3; mid[1][1] = 12; mid[1][2] = 9; mid[1][3] = 20;
        for (int c = 0; c < W; c++) begin mid[0][c] = 25; mid[2][c] = 25; end
        run(1, 4, 10, 0, 0, "basic");
        check_r1("basic_c0", 0, 0, 0);
        check_r1("basic_c1", 1, 12, 2);
        check_r1("basic_c2", 2, 0, 0);
        check_r1("basic_c3", 3, 0, 0);

        // Each angle: larger at matching pair, larger elsewhere, equal at matching pair
        for (int a = 0; a < 4; a++) begin
            for (int v = 0; v < 3; v++) begin
                clear_img();
                mid[1][1] = 10; ang[1][1] = a;
                case (v)
                    0:       put_nb(a, $urandom_range(0, 1), 20);
                    1:       put_nb((a + 1) % 4, $urandom_range(0, 1), 20);
                    default: put_nb(a, $urandom_range(0, 1), 10);
                endcase
                run(1, 4, 10, 0, 0, $sformatf("ang%0d_v%0d", a, v));
                check_r1($sformatf("ang%0d_v%0d_ctr", a, v), 1, (v == 0) ? 0 : 10, (v == 0) ? 0 : 2);
            end
        end

        // Bypass: large neighbours everywhere do not suppress
        for (int f = 0; f < 2; f++) begin
            rand_img();
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++) begin top[r][c] = 31; mid[r][c] = 31; bot[r][c] = 31; end
            mid[1][1] = (f == 0) ? 5 : 10;
            mid[1][2] = 3;
            run(0, 4, 10, 0, 0, $sformatf("bypass%0d", f));
            check_r1($sformatf("bypass%0d_c1", f), 1, (f == 0) ? 5 : 10, (f == 0) ? 1 : 2);
            check_r1($sformatf("bypass%0d_c2", f), 2, 3, 0);
            check_r1($sformatf("bypass%0d_c0", f), 0, 0, 0);
            check_r1($sformatf("bypass%0d_c3", f), 3, 0, 0);
        end

        // Inverted thresholds: empty weak band
        clear_img();
        mid[1][1] = 12; mid[1][2] = 7;
        run(0, 15, 8, 0, 0, "inv_thr");
        check_r1("inv_thr_12", 1, 12, 2);
        check_r1("inv_thr_7", 2, 7, 0);

        // Random frames, alternating bubble-free and ~50% bubbles on the same image
        for (int f = 0; f < 10; f++) begin
            rand_img();
            lo  = $urandom_range(0, 31);
            hi  = $urandom_range(0, 31);
            nms = $urandom_range(0, 1);
            run(nms, lo, hi, 0, 0, $sformatf("rnd%0d_clean", f));
            run(nms, lo, hi, 50, (f == 3), $sformatf("rnd%0d_bubbles", f));
        end

        // Reset in the middle of row 1, then a clean frame
        rand_img();
        lo = $urandom_range(0, 31);
        hi = $urandom_range(0, 31);
        start_frame(1, lo, hi);
        drive_frame(20, W + 2, 0);
        @(negedge clk);
        reset = 1'b0; bus.in_valid = 1'b0;
        @(negedge clk);
        check_idle_outputs("midrst");
        @(negedge clk);
        reset = 1'b1;
        rand_img();
        run(1, lo, hi, 30, 0, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/nonmax_thresh_stream.md
Name: nonmax_thresh_stream

Overview:
Parametrised streaming non-maximum suppression with double-threshold classification for the Canny edge pipeline. It sits between the gradient/angle stage and the hysteresis stage. Each accepted beat is one 3-pixel column (rows r-1, r, r+1) plus the quantised gradient angle of the centre pixel. It emits one suppressed pixel and a 2-bit edge class per image column, and it handles row and frame borders, row-end flush and a valid/ready input handshake.

Parameters:
BIT_LENGTH, 5, pixel/magnitude width.
IMG_WIDTH, 960, columns per row; must be >= 3.
IMG_HEIGHT, 720, rows per frame; must be >= 3.
Derived column and row counter widths: clog2(IMG_WIDTH) and clog2(IMG_HEIGHT).

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE or DONE.
nms_en  in  1  1 = suppression on; 0 = bypass (centre pixel passed through, classification still applied). Sampled at start.
thr_low  in  BIT_LENGTH  weak threshold. Sampled at start.
thr_high  in  BIT_LENGTH  strong threshold. Sampled at start.
in_valid  in  1  input column valid.
in_ready  out  1  block can accept a column this cycle.
angle  in  2  direction code of the centre pixel of this column.
pixel_in0  in  BIT_LENGTH  row r-1 (top).
pixel_in1  in  BIT_LENGTH  row r (centre).
pixel_in2  in  BIT_LENGTH  row r+1 (bottom).
out_valid  out  1  output beat valid. The downstream stage always accepts; there is no output backpressure.
pixel_out  out  BIT_LENGTH  suppressed magnitude.
edge_class  out  2  00 none, 01 weak, 10 strong; 11 is never driven.
out_col  out  clog2(IMG_WIDTH)  column index of the current output.
busy  out  1  high in RUN and FLUSH.
frame_done  out  1  one-cycle pulse on entry to DONE.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. All outputs 0, including in_ready, out_valid, pixel_out, edge_class, out_col, busy and frame_done. Window registers, counters and latched thresholds clear to 0.
- States and transitions:
  - IDLE: start -> RUN, latching nms_en, thr_low and thr_high.
  - RUN: in_ready=1. Accept when in_valid & in_ready. Accepting column IMG_WIDTH-1 -> FLUSH.
  - FLUSH: exactly one cycle, in_ready=0. -> RUN if more rows remain; -> DONE after row IMG_HEIGHT-1.
  - DONE: in_ready=0. start -> RUN (new frame, thresholds re-latched).
- Window: three column registers, each holding 3 pixels plus an angle. They shift only on acceptance: new beat -> col2, col2 -> col1, col1 -> col0. Column and row counters advance on acceptance; column wraps at IMG_WIDTH-1 and row increments on the wrap.
- Output timing:
  - Accepting column k (k >= 1) gives out_valid=1 in the next cycle, carrying centre column k-1 (out_col=k-1).
  - Accepting column 0 produces no output.
  - In the cycle after FLUSH, column IMG_WIDTH-1 is emitted as a border beat.
  - Every row therefore yields exactly IMG_WIDTH output beats, in column order.
  - out_valid is 0 in every other cycle, and pixel_out/edge_class hold their last values.
- Suppression: centre is col1 row1 and the angle is col1's angle. A neighbour suppresses only if strictly greater than the centre (equal does not suppress):
  - 00: compare col0.row1 and col2.row1.
  - 01: compare col0.row2 and col2.row0.
  - 10: compare col1.row0 and col1.row2.
  - 11: compare col0.row0 and col2.row2.
  - Suppressed gives pixel_out=0. nms_en=0 skips the comparison.
- Borders: output column 0, output column IMG_WIDTH-1, row 0 and row IMG_HEIGHT-1 force pixel_out=0 and edge_class=00.
- Classification, on the post-suppression value v, unsigned: v >= thr_high gives 10; else v >= thr_low and v != 0 gives 01; else 00. If thr_low > thr_high, the weak band is empty (only 10 or 00).
- Input bubbles (in_valid=0 in RUN): no shift, no output, and the window is preserved. Bubbles may occur at any column.
- start while busy is ignored.
- Reset asserted mid-frame aborts immediately to the IDLE reset values. Partial-row data is discarded.

Test Plan:
- BIT_LENGTH=5, W=4, H=3, nms_en=1, thr 4/10, angle 00 everywhere, centre row 1 = {3,12,9,20}: row 1 outputs (0,00),(12,10),(0,00),(0,00). Col 2 is suppressed because 20>9. Rows 0 and 2 output all zero. frame_done pulses 2 cycles after the last accept.
- Each angle code with a strictly larger pixel placed at exactly the matching neighbour pair -> pixel_out=0. With the same value placed at a non-matching position -> centre passes. A neighbour equal to the centre -> centre passes.
- nms_en=0, thr 4/10, centre values {5,3,10} -> weak(5,01), none(3,00), strong(10,10). Border columns are still zero.
- Random in_valid bubbles (about 50%) -> output sequence identical to the bubble-free run. in_ready=0 during every FLUSH cycle. Exactly W beats per row.
- thr_low=15, thr_high=8, value 12 -> class 10; value 7 -> class 00.
- Assert reset mid-row 1, then start -> all outputs 0 during reset. The new frame's outputs match a clean run; no stale window data appears.
